alt_vipswi131_common_mode_select_ctrl: RTL
==========================================

Name: alt_vipswi131_common_mode_select_ctrl

Overview:
- Registered, debounced successor to the combinational one-hot-to-binary converter used by the switch.
- Encodes an N-way one-hot mode request to binary with selectable priority and offset.
- Qualifies the request for stability, then applies the mode change only at a safe boundary, e.g. end of frame.
- Sits between the control-register slave and the switch datapath mux select.

Parameters:
- NO_OF_MODES, 3, number of one-hot request lines.
- LOG2_NO_OF_MODES, 2, binary output width; must be >= clog2(NO_OF_MODES+BINARY_OFFSET).
- BINARY_OFFSET, 1, binary code is index+BINARY_OFFSET. With 1, code 0 means "no mode"; with 0, code 0 is mode 0.
- STABLE_CYCLES, 4, consecutive identical encoded requests needed before a change qualifies (>=1).
- PRIORITY_LSB, 1, on multi-hot input: 1 = lowest set index wins, 0 = highest set index wins.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- one_hot_req  in  NO_OF_MODES  requested mode (one-hot; 0 = none).
- boundary  in  1  safe-switch strobe, one cycle; may be high any cycle.
- err_clear  in  1  clears multi_hot_err.
- binary  out  LOG2_NO_OF_MODES  active mode code (registered).
- one_hot  out  NO_OF_MODES  active mode, one-hot (registered, always exactly 0 or 1 bit set).
- active_valid  out  1  a mode is active.
- change_pending  out  1  qualified change waiting for boundary.
- switch_pulse  out  1  one-cycle pulse in the cycle new outputs first appear.
- multi_hot_err  out  1  sticky: more than one request bit seen.

Behaviour:
- Reset: binary=0, one_hot=0, active_valid=0, change_pending=0, switch_pulse=0, multi_hot_err=0. Candidate=none, counter=0, state IDLE.
- Any reset mid-operation discards pending changes.

Encoding (combinational):
- req_code = priority-encoded index+BINARY_OFFSET. req_none when one_hot_req==0.
- Multi-hot resolves per PRIORITY_LSB and sets multi_hot_err on the next edge.
- err_clear and a new multi-hot in the same cycle: the error stays set.

Stability:
- Registers cand (code+none flag) and cnt (saturating at STABLE_CYCLES-1).
- If the request differs from cand: cand<=request, cnt<=0. Otherwise cnt increments to saturation.
- stable = (request==cand) && cnt==STABLE_CYCLES-1.
- A request held from cycle T becomes stable in cycle T+STABLE_CYCLES.

FSM states: IDLE (no active mode), RUN (mode active), PENDING (qualified change waiting).
- IDLE/RUN -> PENDING when stable and cand differs from the active mode (including the none/active difference) and boundary is low.
- Any state with stable && differs && boundary -> apply. Outputs update on that edge, switch_pulse is high the following cycle, and the state becomes RUN, or IDLE if cand is none.
- PENDING -> back to RUN/IDLE (per active_valid) when the request changes before the boundary. The change is abandoned and no pulse is generated.
- PENDING with stable && cand==active again (request reverted, then restabilised) -> RUN/IDLE with no pulse.
- Boundary with nothing qualified has no effect.
- change_pending = (state==PENDING).
- Request for none, once qualified and at a boundary, deactivates: binary=0 (offset 1), one_hot=0, active_valid=0.
- With BINARY_OFFSET=0, binary is 0 when inactive and active_valid disambiguates.
- Latency: request held from T, boundary at B>=T+STABLE_CYCLES -> outputs and switch_pulse valid at B+1.

Decomposition:
- Shared include/package: a clog2 constant function, state encodings (IDLE=2'd0, RUN=2'd1, PENDING=2'd2), and a parameter-legality check macro.
- Sub-module alt_vipswi131_common_prio_encoder: combinational priority encoder (one_hot -> code, none, multi) with PRIORITY_LSB and BINARY_OFFSET parameters.

Test Plan:
- Defaults: req=3'b010 from cycle 0, held; boundary at cycle 10 -> change_pending high cycles 5-10; binary=2, one_hot=3'b010, active_valid=1, switch_pulse=1 at cycle 11 only.
- Active mode 2: req toggles 3'b100 for 2 cycles, then back to 3'b010; boundaries every 3 cycles -> no switch_pulse, binary stays 2, change_pending never high.
- Multi-hot req=3'b110: PRIORITY_LSB=1 -> binary=2; PRIORITY_LSB=0 -> binary=3. multi_hot_err=1 sticky until err_clear; clears the cycle after err_clear.
- Active mode 1: req=0 held 4 cycles, then boundary -> next cycle binary=0, one_hot=0, active_valid=0, switch_pulse=1.
- PENDING with change to mode 3 and reset asserted before boundary -> all outputs 0. Boundary after reset release yields no change until re-qualified (4 cycles).
- STABLE_CYCLES=1, NO_OF_MODES=7, LOG2=3: req=7'b1000000 at cycle 0 with boundary at cycle 1 -> binary=7 and switch_pulse at cycle 2.

Source files
------------

// File: rtl/alt_vipswi131_common_mode_select_ctrl_pkg.sv
// Shared constants for the mode-select controller: state codes, clog2 helper,
// and a parameter-legality check usable inside a module body.
`ifndef ALT_VIPSWI131_CHECK_PARAM
`define ALT_VIPSWI131_CHECK_PARAM(cond, msg) \
  if (!(cond)) begin : g_param_check \
    $error(msg); \
  end
`endif

package alt_vipswi131_common_mode_select_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alt_vipswi131_common_prio_encoder.sv
// Combinational one-hot to binary priority encoder; also returns the resolved
// single-bit select so the caller never sees a multi-hot one-hot.
module alt_vipswi131_common_prio_encoder #(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int BINARY_OFFSET    = 1,
  parameter int PRIORITY_LSB     = 1
) (
  input  logic [NO_OF_MODES-1:0]      one_hot_i,
  output logic [LOG2_NO_OF_MODES-1:0] code_o,
  output logic [NO_OF_MODES-1:0]      sel_o,
  output logic                        none_o,
  output logic                        multi_o
);

  // Scan so the winning index is the last one written.
  always_comb begin
    code_o = '0;
    sel_o  = '0;
    for (int i = 0; i < NO_OF_MODES; i++) begin
      if (PRIORITY_LSB != 0) begin
        if (one_hot_i[NO_OF_MODES-1-i]) begin
          code_o = LOG2_NO_OF_MODES'(NO_OF_MODES - 1 - i + BINARY_OFFSET);
          sel_o  = '0;
          sel_o[NO_OF_MODES-1-i] = 1'b1;
        end
      end else if (one_hot_i[i]) begin
        code_o   = LOG2_NO_OF_MODES'(i + BINARY_OFFSET);
        sel_o    = '0;
        sel_o[i] = 1'b1;
      end
    end
  end

  assign none_o  = (one_hot_i == '0);
  assign multi_o = ($countones(one_hot_i) > 1);

endmodule

// File: rtl/alt_vipswi131_common_mode_select_ctrl.sv
// Debounced mode select: a request must hold for STABLE_CYCLES before it
// qualifies, and the active mode only changes on a boundary strobe.
module alt_vipswi131_common_mode_select_ctrl
  import alt_vipswi131_common_mode_select_ctrl_pkg::*;
#(
  parameter int NO_OF_MODES      = 3,
  parameter int LOG2_NO_OF_MODES = 2,
  parameter int BINARY_OFFSET    = 1,
  parameter int STABLE_CYCLES    = 4,
  parameter int PRIORITY_LSB     = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NO_OF_MODES-1:0]      one_hot_req,
  input  logic                        boundary,
  input  logic                        err_clear,
  output logic [LOG2_NO_OF_MODES-1:0] binary,
  output logic [NO_OF_MODES-1:0]      one_hot,
  output logic                        active_valid,
  output logic                        change_pending,
  output logic                        switch_pulse,
  output logic                        multi_hot_err
);

  localparam int CW = (STABLE_CYCLES > 1) ? clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  `ALT_VIPSWI131_CHECK_PARAM((NO_OF_MODES >= 1) && (STABLE_CYCLES >= 1) &&
    (LOG2_NO_OF_MODES >= clog2(NO_OF_MODES + BINARY_OFFSET)),
    "alt_vipswi131_common_mode_select_ctrl: illegal parameter combination")

  logic [LOG2_NO_OF_MODES-1:0] req_code;
  logic [NO_OF_MODES-1:0]      req_sel;
  logic                        req_none, req_multi;

  alt_vipswi131_common_prio_encoder #(
    .NO_OF_MODES     (NO_OF_MODES),
    .LOG2_NO_OF_MODES(LOG2_NO_OF_MODES),
    .BINARY_OFFSET   (BINARY_OFFSET),
    .PRIORITY_LSB    (PRIORITY_LSB)
  ) u_enc (
    .one_hot_i(one_hot_req),
    .code_o   (req_code),
    .sel_o    (req_sel),
    .none_o   (req_none),
    .multi_o  (req_multi)
  );

  logic [LOG2_NO_OF_MODES-1:0] cand_code_q, cand_code_d;
  logic [NO_OF_MODES-1:0]      cand_sel_q, cand_sel_d;
  logic                        cand_none_q, cand_none_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [1:0]                  state_q, state_d;
  logic [LOG2_NO_OF_MODES-1:0] binary_q, binary_d;
  logic [NO_OF_MODES-1:0]      one_hot_q, one_hot_d;
  logic                        active_q, active_d;
  logic                        pulse_q, pulse_d;
  logic                        err_q, err_d;

  logic same_req, stable, differs, apply;

  // Code is forced to 0 for "none", so code+flag compare is unambiguous for any offset.
  assign same_req = (req_none == cand_none_q) && (req_code == cand_code_q);
  assign stable   = same_req && (cnt_q == CNT_MAX);
  assign differs  = (cand_none_q == active_q) ||
                    (!cand_none_q && (cand_code_q != binary_q));
  assign apply    = stable && differs && boundary;

  always_comb begin
    cand_code_d = cand_code_q;
    cand_sel_d  = cand_sel_q;
    cand_none_d = cand_none_q;
    cnt_d       = cnt_q;
    if (!same_req) begin
      cand_code_d = req_code;
      cand_sel_d  = req_sel;
      cand_none_d = req_none;
      cnt_d       = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    binary_d  = binary_q;
    one_hot_d = one_hot_q;
    active_d  = active_q;
    pulse_d   = 1'b0;
    if (apply) begin
      binary_d  = cand_code_q;
      one_hot_d = cand_sel_q;
      active_d  = !cand_none_q;
      pulse_d   = 1'b1;
      state_d   = cand_none_q ? ST_IDLE : ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE, ST_RUN: if (stable && differs) state_d = ST_PENDING;
        // Leave when the request moves away or settles back on the active mode.
        ST_PENDING: if (!same_req || (stable && !differs))
                      state_d = active_q ? ST_RUN : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign err_d = req_multi | (err_q & ~err_clear);

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_code_q <= '0;
      cand_sel_q  <= '0;
      cand_none_q <= 1'b1;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      binary_q    <= '0;
      one_hot_q   <= '0;
      active_q    <= 1'b0;
      pulse_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cand_code_q <= cand_code_d;
      cand_sel_q  <= cand_sel_d;
      cand_none_q <= cand_none_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      binary_q    <= binary_d;
      one_hot_q   <= one_hot_d;
      active_q    <= active_d;
      pulse_q     <= pulse_d;
      err_q       <= err_d;
    end
  end

  assign binary         = binary_q;
  assign one_hot        = one_hot_q;
  assign active_valid   = active_q;
  assign change_pending = (state_q == ST_PENDING);
  assign switch_pulse   = pulse_q;
  assign multi_hot_err  = err_q;

endmodule
